uart_xcvr_core: RTL and testbench
=================================

// Module: uart_xcvr_core
// PURPOSE
// - Synthesizable, parametrised UART transceiver core: one TX and one RX channel sharing a runtime baud divider.
// - Configurable data width, parity, stop bits and oversampling.
// - Adds mid-bit 3-sample majority voting, start-bit glitch rejection, frame/parity/overrun flags and idle status.
// - Sits between a register/FIFO front end and the chip pads; its pins are driven and monitored by uart_agent.
// PARAMETERS
// - DataWidth  8   data bits per frame, legal 5..9, sent LSB first
// - Oversample 16  ticks per bit, even, legal 8..64
// - DivWidth   16  width of baud_div_i
// - ParityEn   0   1: parity bit after data
// - ParityOdd  0   1: odd parity, 0: even (ignored if ParityEn=0)
// - StopBits   1   1 or 2 stop bits
// PORTS
// - clk_i            in   1          core clock
// - rst_i            in   1          synchronous active-high reset
// - baud_div_i       in   DivWidth   tick period = baud_div_i+1 clocks
// - tx_valid_i       in   1          TX data valid
// - tx_ready_o       out  1          TX accepts data (high only in IDLE)
// - tx_data_i        in   DataWidth  TX data
// - tx_o             out  1          serial out, idle high
// - rx_i             in   1          serial in, asynchronous
// - rx_valid_o       out  1          RX data valid, held until rx_ready_i
// - rx_ready_i       in   1          consumer takes RX data
// - rx_data_o        out  DataWidth  RX data
// - rx_parity_err_o  out  1          qualifies rx_data_o; parity mismatch
// - rx_frame_err_o   out  1          qualifies rx_data_o; a stop bit sampled 0
// - rx_overrun_o     out  1          1-cycle pulse: frame dropped, rx_valid_o still set
// - rx_glitch_o      out  1          1-cycle pulse: start bit rejected
// - tx_idle_o        out  1          TX FSM in IDLE
// - rx_idle_o        out  1          RX FSM in IDLE
// BEHAVIOUR
// - Reset values: tx_o=1, tx_ready_o=1, tx_idle_o=1, rx_idle_o=1. All other outputs 0. Synchronizer flops = 1.
// - Reset mid-frame aborts both FSMs. tx_o=1 from the cycle after rst_i is sampled.
// - Baud: each FSM has its own tick counter. baud_div_i is latched when the frame starts.
//   - Counter counts 0..div. tick fires on div, then wraps to 0.
//   - Bit time = Oversample*(div+1) clocks. div=0 gives a tick every clock.
// - TX FSM: IDLE -> START -> DATA(xDataWidth) -> [PARITY] -> STOP(xStopBits) -> IDLE.
//   - Handshake tx_valid_i&tx_ready_o in IDLE captures the data.
//   - tx_o goes 0 the next cycle. Each bit is held exactly one bit time.
//   - Parity = ^data ^ ParityOdd.
//   - Back-to-back frames: tx_ready_o rises the cycle after the last stop bit ends. Minimum gap is 0 bits.
// - RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - rx_i passes through a 2-flop synchronizer.
//   - IDLE->START when the synced rx is 0. The tick counter and oversample counter restart at 0.
//   - Each bit is sampled on oversample ticks Oversample/2-1, /2 and /2+1. Bit value = 2-of-3 majority.
//   - START majority 1: rx_glitch_o pulse, return to IDLE.
//   - After the mid-sample of the last stop bit: go to IDLE, set rx_valid_o and the flags the next cycle.
//     Leaving half a bit early allows back-to-back frames.
//   - Stop bits: each stop bit is checked. Any 0 sets rx_frame_err_o; the data is still delivered.
//   - Frame completes while rx_valid_o=1 and rx_ready_i=0: drop the new frame, pulse rx_overrun_o, hold the old data and flags.
//   - Frame completes in the same cycle as rx_ready_i&rx_valid_o: the new frame replaces the old one with no overrun.
// - TX and RX are fully independent. External loopback is legal.
// TESTING
// - DW=8, OS=16, div=0, no parity. Send 0xA5 -> tx_o: 0 for 16 clks, then 1,0,1,0,0,1,0,1 (16 clks each), then 1. tx_ready_o high again 160 clks after the handshake.
// - Loopback tx_o->rx_i, div=3, ParityEn=1 ParityOdd=1, 0x3C -> rx_valid_o with rx_data_o=0x3C, parity_err=0, frame_err=0.
// - Force rx_i low 4 clks (div=0) -> rx_glitch_o pulse, no rx_valid_o, rx_idle_o=1 afterwards.
// - RX frame 0x55 with stop bit driven 0 -> rx_valid_o, rx_data_o=0x55, rx_frame_err_o=1. Frame with a flipped parity bit -> rx_parity_err_o=1.
// - Two frames 0x11, 0x22 with rx_ready_i=0 -> rx_overrun_o pulse at the second frame end, rx_data_o stays 0x11.
// - Single-sample glitch inside data bit 3 (one of three votes) -> correct data. rst_i mid-TX-frame -> tx_o=1, tx_idle_o=1 next cycle.

Source files
------------

// File: rtl/uart_xcvr_core.sv
// UART transceiver core: independent TX and RX channels sharing a runtime baud divider,
// with 3-sample majority voting, start-glitch rejection and frame/parity/overrun flags.
module uart_xcvr_core #(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned Oversample = 16,
  parameter int unsigned DivWidth   = 16,
  parameter int unsigned ParityEn   = 0,
  parameter int unsigned ParityOdd  = 0,
  parameter int unsigned StopBits   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DivWidth-1:0]  baud_div_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DataWidth-1:0] tx_data_i,
  output logic                 tx_o,
  input  logic                 rx_i,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_overrun_o,
  output logic                 rx_glitch_o,
  output logic                 tx_idle_o,
  output logic                 rx_idle_o
);

  localparam int unsigned OW = $clog2(Oversample);
  localparam int unsigned BW = $clog2(DataWidth + 1);
  localparam logic [OW-1:0] OsLast   = OW'(Oversample - 1);
  localparam logic [OW-1:0] OsVote0  = OW'(Oversample / 2 - 1);
  localparam logic [OW-1:0] OsVote1  = OW'(Oversample / 2);
  localparam logic [OW-1:0] OsVote2  = OW'(Oversample / 2 + 1);
  localparam logic [BW-1:0] DataLast = BW'(DataWidth - 1);
  localparam logic [BW-1:0] StopLast = BW'(StopBits - 1);
  localparam logic          HasPar   = (ParityEn != 0);
  localparam logic          PolOdd   = (ParityOdd != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------------------------------------------------------- TX
  state_e               r_tx_state, w_tx_state_d;
  logic [DivWidth-1:0]  r_tx_div, w_tx_div_d, r_tx_tick, w_tx_tick_d;
  logic [OW-1:0]        r_tx_os, w_tx_os_d;
  logic [BW-1:0]        r_tx_bit, w_tx_bit_d;
  logic [DataWidth-1:0] r_tx_shift, w_tx_shift_d;
  logic                 r_tx_par, w_tx_par_d, r_tx_o, w_tx_o_d;
  logic                 w_tx_tick, w_tx_bit_end;

  assign w_tx_tick    = (r_tx_tick == r_tx_div);
  assign w_tx_bit_end = w_tx_tick && (r_tx_os == OsLast);

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_div_d   = r_tx_div;
    w_tx_tick_d  = r_tx_tick;
    w_tx_os_d    = r_tx_os;
    w_tx_bit_d   = r_tx_bit;
    w_tx_shift_d = r_tx_shift;
    w_tx_par_d   = r_tx_par;
    w_tx_o_d     = r_tx_o;
    if (r_tx_state != S_IDLE) begin
      w_tx_tick_d = w_tx_tick ? '0 : r_tx_tick + 1'b1;
      if (w_tx_tick) w_tx_os_d = (r_tx_os == OsLast) ? '0 : r_tx_os + 1'b1;
    end
    // tx_o is registered from the next-state view so each level starts on the bit edge
    case (r_tx_state)
      S_IDLE: if (tx_valid_i) begin
        w_tx_state_d = S_START;
        w_tx_div_d   = baud_div_i;
        w_tx_tick_d  = '0;
        w_tx_os_d    = '0;
        w_tx_shift_d = tx_data_i;
        w_tx_par_d   = ^tx_data_i ^ PolOdd;
        w_tx_o_d     = 1'b0;
      end
      S_START: if (w_tx_bit_end) begin
        w_tx_state_d = S_DATA;
        w_tx_bit_d   = '0;
        w_tx_o_d     = r_tx_shift[0];
      end
      S_DATA: if (w_tx_bit_end) begin
        if (r_tx_bit == DataLast) begin
          w_tx_bit_d = '0;
          if (HasPar) begin
            w_tx_state_d = S_PARITY;
            w_tx_o_d     = r_tx_par;
          end else begin
            w_tx_state_d = S_STOP;
            w_tx_o_d     = 1'b1;
          end
        end else begin
          w_tx_bit_d   = r_tx_bit + 1'b1;
          w_tx_shift_d = r_tx_shift >> 1;
          w_tx_o_d     = r_tx_shift[1];
        end
      end
      S_PARITY: if (w_tx_bit_end) begin
        w_tx_state_d = S_STOP;
        w_tx_bit_d   = '0;
        w_tx_o_d     = 1'b1;
      end
      S_STOP: if (w_tx_bit_end) begin
        w_tx_o_d = 1'b1;
        if (r_tx_bit == StopLast) w_tx_state_d = S_IDLE;
        else                      w_tx_bit_d   = r_tx_bit + 1'b1;
      end
      default: w_tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= S_IDLE;
      r_tx_div   <= '0;
      r_tx_tick  <= '0;
      r_tx_os    <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_o     <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_div   <= w_tx_div_d;
      r_tx_tick  <= w_tx_tick_d;
      r_tx_os    <= w_tx_os_d;
      r_tx_bit   <= w_tx_bit_d;
      r_tx_shift <= w_tx_shift_d;
      r_tx_par   <= w_tx_par_d;
      r_tx_o     <= w_tx_o_d;
    end
  end

  assign tx_o       = r_tx_o;
  assign tx_ready_o = (r_tx_state == S_IDLE);
  assign tx_idle_o  = (r_tx_state == S_IDLE);

  // ---------------------------------------------------------------- RX
  state_e               r_rx_state, w_rx_state_d;
  logic                 r_rx_s1, r_rx_s2;
  logic [DivWidth-1:0]  r_rx_div, w_rx_div_d, r_rx_tick, w_rx_tick_d;
  logic [OW-1:0]        r_rx_os, w_rx_os_d;
  logic [BW-1:0]        r_rx_bit, w_rx_bit_d;
  logic [DataWidth-1:0] r_rx_shift, w_rx_shift_d, r_rx_data;
  logic [1:0]           r_rx_votes, w_rx_votes_d;
  logic                 r_rx_parbit, w_rx_parbit_d, r_rx_ferr, w_rx_ferr_d;
  logic                 r_rx_valid, r_rx_perr_o, r_rx_ferr_o, r_rx_ovr, r_rx_glitch;
  logic                 w_rx_tick, w_rx_bit_end, w_rx_vote, w_rx_vote_last, w_rx_maj;
  logic                 w_rx_done, w_rx_glitch, w_rx_perr;

  assign w_rx_tick      = (r_rx_tick == r_rx_div);
  assign w_rx_bit_end   = w_rx_tick && (r_rx_os == OsLast);
  assign w_rx_vote      = w_rx_tick && ((r_rx_os == OsVote0) || (r_rx_os == OsVote1));
  assign w_rx_vote_last = w_rx_tick && (r_rx_os == OsVote2);
  assign w_rx_maj       = (r_rx_votes[1] & r_rx_votes[0]) | (r_rx_votes[1] & r_rx_s2) |
                          (r_rx_votes[0] & r_rx_s2);
  assign w_rx_perr      = HasPar & (^r_rx_shift ^ PolOdd ^ r_rx_parbit);

  always_comb begin
    w_rx_state_d  = r_rx_state;
    w_rx_div_d    = r_rx_div;
    w_rx_tick_d   = r_rx_tick;
    w_rx_os_d     = r_rx_os;
    w_rx_bit_d    = r_rx_bit;
    w_rx_shift_d  = r_rx_shift;
    w_rx_votes_d  = r_rx_votes;
    w_rx_parbit_d = r_rx_parbit;
    w_rx_ferr_d   = r_rx_ferr;
    w_rx_done     = 1'b0;
    w_rx_glitch   = 1'b0;
    if (r_rx_state != S_IDLE) begin
      w_rx_tick_d = w_rx_tick ? '0 : r_rx_tick + 1'b1;
      if (w_rx_tick) w_rx_os_d = (r_rx_os == OsLast) ? '0 : r_rx_os + 1'b1;
      if (w_rx_vote) w_rx_votes_d = {r_rx_votes[0], r_rx_s2};
    end
    case (r_rx_state)
      S_IDLE: if (!r_rx_s2) begin
        w_rx_state_d = S_START;
        w_rx_div_d   = baud_div_i;
        w_rx_tick_d  = '0;
        w_rx_os_d    = '0;
        w_rx_ferr_d  = 1'b0;
      end
      S_START: begin
        if (w_rx_vote_last && w_rx_maj) begin
          w_rx_state_d = S_IDLE;
          w_rx_glitch  = 1'b1;
        end else if (w_rx_bit_end) begin
          w_rx_state_d = S_DATA;
          w_rx_bit_d   = '0;
        end
      end
      S_DATA: begin
        if (w_rx_vote_last) w_rx_shift_d = {w_rx_maj, r_rx_shift[DataWidth-1:1]};
        if (w_rx_bit_end) begin
          if (r_rx_bit == DataLast) begin
            w_rx_state_d = HasPar ? S_PARITY : S_STOP;
            w_rx_bit_d   = '0;
          end else begin
            w_rx_bit_d = r_rx_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_rx_vote_last) w_rx_parbit_d = w_rx_maj;
        if (w_rx_bit_end) begin
          w_rx_state_d = S_STOP;
          w_rx_bit_d   = '0;
        end
      end
      // The last stop bit ends at its vote so a following start edge is not missed
      S_STOP: begin
        if (w_rx_vote_last) begin
          w_rx_ferr_d = r_rx_ferr | ~w_rx_maj;
          if (r_rx_bit == StopLast) begin
            w_rx_state_d = S_IDLE;
            w_rx_done    = 1'b1;
          end
        end else if (w_rx_bit_end) begin
          w_rx_bit_d = r_rx_bit + 1'b1;
        end
      end
      default: w_rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_state  <= S_IDLE;
      r_rx_div    <= '0;
      r_rx_tick   <= '0;
      r_rx_os     <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_votes  <= '0;
      r_rx_parbit <= 1'b0;
      r_rx_ferr   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_perr_o <= 1'b0;
      r_rx_ferr_o <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_rx_glitch <= 1'b0;
    end else begin
      r_rx_s1     <= rx_i;
      r_rx_s2     <= r_rx_s1;
      r_rx_state  <= w_rx_state_d;
      r_rx_div    <= w_rx_div_d;
      r_rx_tick   <= w_rx_tick_d;
      r_rx_os     <= w_rx_os_d;
      r_rx_bit    <= w_rx_bit_d;
      r_rx_shift  <= w_rx_shift_d;
      r_rx_votes  <= w_rx_votes_d;
      r_rx_parbit <= w_rx_parbit_d;
      r_rx_ferr   <= w_rx_ferr_d;
      r_rx_glitch <= w_rx_glitch;
      r_rx_ovr    <= 1'b0;
      if (w_rx_done) begin
        if (r_rx_valid && !rx_ready_i) begin
          r_rx_ovr <= 1'b1;
        end else begin
          r_rx_valid  <= 1'b1;
          r_rx_data   <= w_rx_shift_d;
          r_rx_perr_o <= w_rx_perr;
          r_rx_ferr_o <= w_rx_ferr_d;
        end
      end else if (r_rx_valid && rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_valid_o      = r_rx_valid;
  assign rx_data_o       = r_rx_data;
  assign rx_parity_err_o = r_rx_perr_o;
  assign rx_frame_err_o  = r_rx_ferr_o;
  assign rx_overrun_o    = r_rx_ovr;
  assign rx_glitch_o     = r_rx_glitch;
  assign rx_idle_o       = (r_rx_state == S_IDLE);

endmodule

// File: tb/tb_uart_xcvr_core.sv
// Self-checking bench for uart_xcvr_core: instance A (8N1) and instance B (8O1, loopback-capable),
// checked against a frame-level bit-list model.
module tb_uart_xcvr_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] div;

  logic       a_tx_valid, a_tx_ready, a_tx_o, a_rx_i, a_rx_valid, a_rx_ready;
  logic       a_perr, a_ferr, a_ovr, a_glitch, a_tx_idle, a_rx_idle;
  logic [7:0] a_tx_data, a_rx_data;
  logic       b_tx_valid, b_tx_ready, b_tx_o, b_rx_i, b_rx_valid, b_rx_ready;
  logic       b_perr, b_ferr, b_ovr, b_glitch, b_tx_idle, b_rx_idle;
  logic [7:0] b_tx_data, b_rx_data;
  logic       b_loop, b_rx_drv;

  assign b_rx_i = b_loop ? b_tx_o : b_rx_drv;

  uart_xcvr_core #(.DataWidth(8), .Oversample(16), .DivWidth(16), .ParityEn(0), .ParityOdd(0),
                   .StopBits(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .baud_div_i(div),
    .tx_valid_i(a_tx_valid), .tx_ready_o(a_tx_ready), .tx_data_i(a_tx_data), .tx_o(a_tx_o),
    .rx_i(a_rx_i), .rx_valid_o(a_rx_valid), .rx_ready_i(a_rx_ready), .rx_data_o(a_rx_data),
    .rx_parity_err_o(a_perr), .rx_frame_err_o(a_ferr), .rx_overrun_o(a_ovr),
    .rx_glitch_o(a_glitch), .tx_idle_o(a_tx_idle), .rx_idle_o(a_rx_idle));

  uart_xcvr_core #(.DataWidth(8), .Oversample(16), .DivWidth(16), .ParityEn(1), .ParityOdd(1),
                   .StopBits(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .baud_div_i(div),
    .tx_valid_i(b_tx_valid), .tx_ready_o(b_tx_ready), .tx_data_i(b_tx_data), .tx_o(b_tx_o),
    .rx_i(b_rx_i), .rx_valid_o(b_rx_valid), .rx_ready_i(b_rx_ready), .rx_data_o(b_rx_data),
    .rx_parity_err_o(b_perr), .rx_frame_err_o(b_ferr), .rx_overrun_o(b_ovr),
    .rx_glitch_o(b_glitch), .tx_idle_o(b_tx_idle), .rx_idle_o(b_rx_idle));

  int checks = 0;
  int failures = 0;
  int glitch_cnt = 0;
  int ovr_cnt = 0;
  logic [9:0] a_rxq[$];
  logic [9:0] b_rxq[$];

  // Collect every accepted RX word as {frame_err, parity_err, data}
  always @(negedge clk) begin
    if (a_glitch) glitch_cnt++;
    if (a_ovr) ovr_cnt++;
    if (a_rx_valid && a_rx_ready) a_rxq.push_back({a_ferr, a_perr, a_rx_data});
    if (b_rx_valid && b_rx_ready) b_rxq.push_back({b_ferr, b_perr, b_rx_data});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line-level frame as a bit list, index 0 first on the wire; B uses odd parity
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input bit par, input bit par_flip,
                                           input bit stop_v, output int n);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    n = 9;
    if (par) begin
      f[n] = ~(^d) ^ par_flip;
      n++;
    end
    f[n] = stop_v;
    n++;
    return f;
  endfunction

  task automatic drive_rx(input bit inst, input logic [15:0] f, input int n, input int glitch_idx);
    int  bt;
    logic v;
    bt = 16 * (int'(div) + 1);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < bt; c++) begin
        v = f[i];
        if (i == glitch_idx && c == 9) v = ~v;
        if (inst) b_rx_drv = v;
        else      a_rx_i   = v;
        step(1);
      end
    end
    if (inst) b_rx_drv = 1'b1;
    else      a_rx_i   = 1'b1;
  endtask

  task automatic tx_frame(input bit inst, input logic [7:0] d);
    logic [15:0] f;
    int   n, bt;
    logic line, rdy;
    f  = mk_frame(d, inst, 1'b0, 1'b1, n);
    bt = 16 * (int'(div) + 1);
    rdy = inst ? b_tx_ready : a_tx_ready;
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL tx_ready_before inst=%0d got=%b expected=1", inst, rdy);
    end
    if (inst) begin b_tx_valid = 1'b1; b_tx_data = d; end
    else      begin a_tx_valid = 1'b1; a_tx_data = d; end
    @(posedge clk);
    #1;
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
    for (int c = 0; c <= n * bt; c++) begin
      @(negedge clk);
      line = inst ? b_tx_o : a_tx_o;
      rdy  = inst ? b_tx_ready : a_tx_ready;
      checks++;
      if (c < n * bt) begin
        if ({line, rdy} !== {f[c/bt], 1'b0}) begin
          failures++;
          $display("FAIL tx_bit inst=%0d clk=%0d got line=%b ready=%b expected line=%b ready=0",
                   inst, c, line, rdy, f[c/bt]);
        end
      end else if ({line, rdy} !== 2'b11) begin
        failures++;
        $display("FAIL tx_ready_after inst=%0d data=%h got line=%b ready=%b expected 1 1",
                 inst, d, line, rdy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++;
    if ({a_tx_o, a_tx_ready, a_tx_idle, a_rx_idle, a_rx_valid, a_perr, a_ferr, a_ovr, a_glitch,
         a_rx_data} !== {4'b1111, 5'b00000, 8'h00}) begin
      failures++;
      $display("FAIL reset_a got %b expected 1111_00000_00000000", {a_tx_o, a_tx_ready, a_tx_idle,
               a_rx_idle, a_rx_valid, a_perr, a_ferr, a_ovr, a_glitch, a_rx_data});
    end
    checks++;
    if ({b_tx_o, b_tx_ready, b_tx_idle, b_rx_idle, b_rx_valid, b_perr, b_ferr, b_ovr, b_glitch,
         b_rx_data} !== {4'b1111, 5'b00000, 8'h00}) begin
      failures++;
      $display("FAIL reset_b got %b expected 1111_00000_00000000", {b_tx_o, b_tx_ready, b_tx_idle,
               b_rx_idle, b_rx_valid, b_perr, b_ferr, b_ovr, b_glitch, b_rx_data});
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_tx();
    div = 16'd0;
    tx_frame(1'b0, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      div = 16'($urandom_range(0, 2));
      tx_frame(k[0], 8'($urandom));
    end
  endtask

  task automatic test_loopback();
    int q0;
    div    = 16'd3;
    b_loop = 1'b1;
    q0     = b_rxq.size();
    tx_frame(1'b1, 8'h3C);
    for (int k = 0; k < 300 && b_rxq.size() == q0; k++) step(1);
    checks++;
    if (b_rxq.size() == q0) begin
      failures++;
      $display("FAIL loopback_timeout got no rx_valid expected one frame");
    end else begin
      checks++;
      if (b_rxq[q0] !== {2'b00, 8'h3C}) begin
        failures++;
        $display("FAIL loopback_data got %h expected %h", b_rxq[q0], {2'b00, 8'h3C});
      end
    end
    b_loop = 1'b0;
    step(20);
  endtask

  task automatic test_glitch();
    int g0, q0;
    div = 16'd0;
    g0  = glitch_cnt;
    q0  = a_rxq.size();
    a_rx_i = 1'b0;
    step(4);
    a_rx_i = 1'b1;
    step(30);
    checks++;
    if (glitch_cnt !== g0 + 1) begin
      failures++;
      $display("FAIL start_glitch_pulses got %0d expected %0d", glitch_cnt - g0, 1);
    end
    checks++;
    if ({a_rxq.size() == q0, a_rx_valid, a_rx_idle} !== 3'b101) begin
      failures++;
      $display("FAIL start_glitch_state got new=%0d valid=%b idle=%b expected new=0 valid=0 idle=1",
               a_rxq.size() - q0, a_rx_valid, a_rx_idle);
    end
  endtask

  task automatic test_rx_back_to_back();
    logic [9:0]  exp[$];
    logic [15:0] f;
    logic [7:0]  d;
    bit          sv;
    int          n, q0;
    q0  = a_rxq.size();
    div = 16'($urandom_range(0, 2));
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      sv = ($urandom_range(0, 3) != 0);
      f  = mk_frame(d, 1'b0, 1'b0, sv, n);
      exp.push_back({~sv, 1'b0, d});
      drive_rx(1'b0, f, n, -1);
      if (!sv) step(2 * 16 * (int'(div) + 1));
    end
    step(40);
    checks++;
    if (a_rxq.size() - q0 !== exp.size()) begin
      failures++;
      $display("FAIL rx_b2b_count got %0d expected %0d", a_rxq.size() - q0, exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (a_rxq[q0+i] !== exp[i]) begin
          failures++;
          $display("FAIL rx_b2b_word%0d got %h expected %h", i, a_rxq[q0+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_rx_frame_err_and_data_glitch();
    logic [15:0] f;
    logic [7:0]  d;
    int          n;
    div = 16'd0;
    f = mk_frame(8'h55, 1'b0, 1'b0, 1'b0, n);
    drive_rx(1'b0, f, n, -1);
    step(40);
    checks++;
    if (a_rxq[$] !== {2'b10, 8'h55}) begin
      failures++;
      $display("FAIL frame_err got %h expected %h", a_rxq[$], {2'b10, 8'h55});
    end
    d = 8'($urandom);
    f = mk_frame(d, 1'b0, 1'b0, 1'b1, n);
    drive_rx(1'b0, f, n, 4);
    step(10);
    checks++;
    if (a_rxq[$] !== {2'b00, d}) begin
      failures++;
      $display("FAIL data_glitch got %h expected %h", a_rxq[$], {2'b00, d});
    end
  endtask

  task automatic test_parity();
    logic [15:0] f;
    logic [7:0]  d;
    bit          flip;
    int          n;
    div = 16'd1;
    for (int k = 0; k < 4; k++) begin
      d    = (k == 0) ? 8'h3C : 8'($urandom);
      flip = k[0];
      f    = mk_frame(d, 1'b1, flip, 1'b1, n);
      drive_rx(1'b1, f, n, -1);
      step(20);
      checks++;
      if (b_rxq[$] !== {1'b0, flip, d}) begin
        failures++;
        $display("FAIL parity%0d got %h expected %h", k, b_rxq[$], {1'b0, flip, d});
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] f;
    int          n, o0;
    div = 16'd0;
    o0  = ovr_cnt;
    a_rx_ready = 1'b0;
    f = mk_frame(8'h11, 1'b0, 1'b0, 1'b1, n);
    drive_rx(1'b0, f, n, -1);
    f = mk_frame(8'h22, 1'b0, 1'b0, 1'b1, n);
    drive_rx(1'b0, f, n, -1);
    step(20);
    checks++;
    if (ovr_cnt !== o0 + 1) begin
      failures++;
      $display("FAIL overrun_pulses got %0d expected 1", ovr_cnt - o0);
    end
    checks++;
    if ({a_rx_valid, a_ferr, a_perr, a_rx_data} !== {3'b100, 8'h11}) begin
      failures++;
      $display("FAIL overrun_hold got %h expected %h", {a_rx_valid, a_ferr, a_perr, a_rx_data},
               {3'b100, 8'h11});
    end
    a_rx_ready = 1'b1;
    step(2);
    checks++;
    if ({a_rx_valid, a_rxq[$]} !== {1'b0, 2'b00, 8'h11}) begin
      failures++;
      $display("FAIL overrun_drain got valid=%b word=%h expected valid=0 word=011", a_rx_valid,
               a_rxq[$]);
    end
  endtask

  task automatic test_tx_reset();
    div = 16'd0;
    a_tx_valid = 1'b1;
    a_tx_data  = 8'h00;
    step(1);
    a_tx_valid = 1'b0;
    step(50);
    checks++;
    if ({a_tx_o, a_tx_idle} !== 2'b00) begin
      failures++;
      $display("FAIL tx_midframe got line=%b idle=%b expected 0 0", a_tx_o, a_tx_idle);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_tx_o, a_tx_idle, a_tx_ready} !== 3'b111) begin
      failures++;
      $display("FAIL tx_reset got line=%b idle=%b ready=%b expected 1 1 1", a_tx_o, a_tx_idle,
               a_tx_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    rst = 1'b1; div = '0; b_loop = 1'b0; b_rx_drv = 1'b1; a_rx_i = 1'b1;
    a_tx_valid = 1'b0; b_tx_valid = 1'b0; a_tx_data = '0; b_tx_data = '0;
    a_rx_ready = 1'b1; b_rx_ready = 1'b1;
    step(1);
    test_reset();
    test_tx();
    test_loopback();
    test_glitch();
    test_rx_back_to_back();
    test_rx_frame_err_and_data_glitch();
    test_parity();
    test_overrun();
    test_tx_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
